// File: rtl/operand_sequencer_if.sv
// Operand sequencer bus: switch/button inputs, adder operands and captured sum.
// master = environment side (switches, button, adder); slave = operand_sequencer.
interface operand_sequencer_if;
    logic [2:0] sw;
    logic       sw_cin;
    logic       btn;
    logic       clr;
    logic [2:0] x;
    logic [2:0] y;
    logic       cin;
    logic [3:0] r_in;
    logic [3:0] result;
    logic       result_valid;
    logic [1:0] state_out;
    logic       busy;

    modport master (
        output sw, sw_cin, btn, clr, r_in,
        input  x, y, cin, result, result_valid, state_out, busy
    );

    modport slave (
        input  sw, sw_cin, btn, clr, r_in,
        output x, y, cin, result, result_valid, state_out, busy
    );
endinterface

// File: rtl/operand_sequencer.sv
// Loads X then Y from switches on button strobes, waits SETTLE cycles, captures the adder sum.
// Optional macro CHAIN_CARRY_EN: carry-in comes from the previous sum's carry instead of sw_cin.
module operand_sequencer #(
    parameter int unsigned SETTLE = 2
) (
    input logic           clk,
    input logic           rst,
    operand_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT_X = 2'b01,
        ADD   = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic       btn_q;
    logic [3:0] cnt;
    logic [2:0] x_q;
    logic [2:0] y_q;
    logic       cin_q;
    logic [3:0] result_q;
    logic       valid_q;
    logic       busy_q;
    logic       strobe;
    logic       sel_cin;

    assign strobe = bus.btn & ~btn_q;

`ifdef CHAIN_CARRY_EN
    logic carry_q;
    logic unused_sw_cin;
    assign unused_sw_cin = bus.sw_cin;
    assign sel_cin       = carry_q;
`else
    assign sel_cin = bus.sw_cin;
`endif

    // btn_q resets high so a button held across reset release is not a strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            btn_q    <= 1'b1;
            cnt      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef CHAIN_CARRY_EN
            carry_q  <= 1'b0;
`endif
        end else begin
            btn_q <= bus.btn;
            if (bus.clr) begin
                state    <= IDLE;
                cnt      <= '0;
                x_q      <= '0;
                y_q      <= '0;
                cin_q    <= 1'b0;
                result_q <= '0;
                valid_q  <= 1'b0;
                busy_q   <= 1'b0;
`ifdef CHAIN_CARRY_EN
                carry_q  <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (strobe) begin
                            x_q   <= bus.sw;
                            state <= GOT_X;
                        end
                    end
                    GOT_X: begin
                        if (strobe) begin
                            y_q    <= bus.sw;
                            cin_q  <= sel_cin;
                            cnt    <= CNT_LOAD;
                            busy_q <= 1'b1;
                            state  <= ADD;
                        end
                    end
                    ADD: begin
                        if (cnt == 4'd0) begin
                            result_q <= bus.r_in;
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            state    <= DONE;
`ifdef CHAIN_CARRY_EN
                            carry_q  <= bus.r_in[3];
`endif
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    DONE: begin
                        if (strobe) begin
                            x_q     <= bus.sw;
                            valid_q <= 1'b0;
                            state   <= GOT_X;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.x            = x_q;
    assign bus.y            = y_q;
    assign bus.cin          = cin_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.state_out    = state;
    assign bus.busy         = busy_q;
endmodule
